// File: rtl/fft_reorder_buf.sv
// Ping/pong reorder buffer: accepts FFT output in bit-reversed order and
// replays each complete frame in natural order with a fixed two-cycle latency.
module fft_reorder_buf #(
  parameter int N    = 256,
  parameter int W    = 16,
  parameter int LOGN = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         in_valid,
  input  logic         in_sop,
  input  logic [W-1:0] Data_in_r,
  input  logic [W-1:0] Data_in_i,
  output logic         out_valid,
  output logic         out_sop,
  output logic [W-1:0] Data_out_r,
  output logic [W-1:0] Data_out_i,
  output logic         frame_err
);

  typedef enum logic { WAIT_SOP, FILL } wr_state_e;
  typedef enum logic { IDLE, DRAIN } rd_state_e;

  function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] a);
    logic [LOGN-1:0] r;
    for (int b = 0; b < LOGN; b++) r[b] = a[LOGN-1-b];
    return r;
  endfunction

  // Address MSB selects the bank; bank_q is the write bank, ~bank_q the read bank.
  logic [2*W-1:0]  mem [2*N];

  wr_state_e       wr_state_q;
  logic [LOGN-1:0] wr_cnt_q;
  logic            bank_q;
  logic            frame_err_q;

  rd_state_e       rd_state_q;
  logic [LOGN-1:0] rd_cnt_q;
  logic            rd_vld_q;
  logic            rd_sop_q;
  logic [2*W-1:0]  rd_data_q;

  logic            out_valid_q;
  logic            out_sop_q;
  logic [2*W-1:0]  out_data_q;

  logic            wr_en;
  logic            swap;
  logic [LOGN-1:0] wr_addr;

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    swap    = 1'b0;
    if (in_valid) begin
      if (in_sop) begin
        wr_en   = 1'b1;
        wr_addr = '0;
      end else if (wr_state_q == FILL) begin
        wr_en   = 1'b1;
        wr_addr = bitrev(wr_cnt_q);
        swap    = (wr_cnt_q == '1);
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_state_q  <= WAIT_SOP;
      wr_cnt_q    <= '0;
      bank_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      if (in_valid) begin
        if (in_sop) begin
          // A restart inside FILL throws away the partial frame.
          frame_err_q <= (wr_state_q == FILL);
          wr_cnt_q    <= LOGN'(1);
          wr_state_q  <= FILL;
        end else if (wr_state_q == FILL) begin
          if (swap) begin
            wr_cnt_q   <= '0;
            wr_state_q <= WAIT_SOP;
            bank_q     <= ~bank_q;
          end else begin
            wr_cnt_q <= wr_cnt_q + LOGN'(1);
          end
        end
      end
    end
  end

  // NOTE: the storage array is deliberately not reset so it maps onto block RAM.
  always_ff @(posedge CLK) begin
    if (wr_en) mem[{bank_q, wr_addr}] <= {Data_in_r, Data_in_i};
    if (rd_state_q == DRAIN) rd_data_q <= mem[{~bank_q, rd_cnt_q}];
  end

  // A swap on the same edge as the last drain read restarts seamlessly.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rd_state_q <= IDLE;
      rd_cnt_q   <= '0;
      rd_vld_q   <= 1'b0;
      rd_sop_q   <= 1'b0;
    end else begin
      rd_vld_q <= (rd_state_q == DRAIN);
      rd_sop_q <= (rd_state_q == DRAIN) && (rd_cnt_q == '0);
      if (swap) begin
        rd_state_q <= DRAIN;
        rd_cnt_q   <= '0;
      end else if (rd_state_q == DRAIN) begin
        if (rd_cnt_q == '1) rd_state_q <= IDLE;
        rd_cnt_q <= rd_cnt_q + LOGN'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= rd_vld_q;
      out_sop_q   <= rd_vld_q & rd_sop_q;
      out_data_q  <= rd_vld_q ? rd_data_q : '0;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_sop    = out_sop_q;
  assign Data_out_r = out_data_q[2*W-1:W];
  assign Data_out_i = out_data_q[W-1:0];
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_fft_reorder_buf.sv
// Randomised bench for fft_reorder_buf: a frame-level model feeds a scoreboard
// queue that an independent monitor drains whenever out_valid is high.
module tb_fft_reorder_buf;

  localparam int N    = 256;
  localparam int W    = 16;
  localparam int LOGN = 8;

  logic         CLK;
  logic         RST;
  logic         in_valid;
  logic         in_sop;
  logic [W-1:0] Data_in_r;
  logic [W-1:0] Data_in_i;
  logic         out_valid;
  logic         out_sop;
  logic [W-1:0] Data_out_r;
  logic [W-1:0] Data_out_i;
  logic         frame_err;

  fft_reorder_buf #(.N(N), .W(W), .LOGN(LOGN)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .in_valid   (in_valid),
    .in_sop     (in_sop),
    .Data_in_r  (Data_in_r),
    .Data_in_i  (Data_in_i),
    .out_valid  (out_valid),
    .out_sop    (out_sop),
    .Data_out_r (Data_out_r),
    .Data_out_i (Data_out_i),
    .frame_err  (frame_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [2*W-1:0] data;
    logic           sop;
    int             due;
  } exp_t;

  exp_t           sb[$];
  logic [2*W-1:0] frame_buf[$];
  bit             in_frame;
  int             tests, fails;
  int             cyc;
  int             err_seen, err_exp;
  int             run;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int rev(input int k);
    int r = 0;
    for (int b = 0; b < LOGN; b++)
      if ((k >> b) & 1) r = r | (1 << (LOGN - 1 - b));
    return r;
  endfunction

  // Frame-level model: natural bin j of a completed frame is input sample rev(j).
  task automatic model(input bit s, input logic [2*W-1:0] d);
    if (s) begin
      if (in_frame) err_exp++;
      frame_buf.delete();
      frame_buf.push_back(d);
      in_frame = 1;
    end else if (in_frame) begin
      frame_buf.push_back(d);
    end
    if (in_frame && frame_buf.size() == N) begin
      for (int j = 0; j < N; j++) begin
        exp_t e;
        e.data = frame_buf[rev(j)];
        e.sop  = (j == 0);
        e.due  = (j == 0) ? cyc + 2 : -1;
        sb.push_back(e);
      end
      frame_buf.delete();
      in_frame = 0;
    end
  endtask

  // Called at posedge+1; returns at the following posedge+1.
  task automatic send(input bit v, input bit s, input logic [W-1:0] re, input logic [W-1:0] im);
    in_valid  = v;
    in_sop    = s;
    Data_in_r = re;
    Data_in_i = im;
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    if (v) model(s, {re, im});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(1'b0, 1'($urandom), W'($urandom), W'($urandom));
  endtask

  task automatic send_frame(input int gapmax, input bit directed, input int len);
    for (int k = 0; k < len; k++) begin
      if (directed) send(1'b1, k == 0, W'(k), W'(-k));
      else          send(1'b1, k == 0, W'($urandom), W'($urandom));
      if (gapmax > 0) idle($urandom_range(0, gapmax));
    end
  endtask

  task automatic wait_drain();
    int i = 0;
    while (sb.size() > 0 && i < 4 * N + 50) begin
      @(negedge CLK);
      i++;
    end
    check("drain_remaining", sb.size(), 0);
    repeat (4) @(posedge CLK);
    #1;
  endtask

  // Monitor: pops one expectation per valid output cycle.
  always @(negedge CLK) begin
    if (!RST) begin
      run = 0;
    end else begin
      if (frame_err) err_seen++;
      if (out_valid) begin
        run++;
        if (sb.size() == 0) begin
          check("unexpected_out_valid", out_valid, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("out_data", {Data_out_r, Data_out_i}, e.data);
          check("out_sop", out_sop, e.sop);
          if (e.due >= 0) check("first_bin_latency", cyc, e.due);
        end
      end else if (run > 0) begin
        check("burst_len_mod_N", run % N, 0);
        check("idle_outputs_zero", {out_sop, Data_out_r, Data_out_i}, 0);
        run = 0;
      end
    end
  end

  initial begin
    bit found;
    RST = 1'b1; in_valid = 1'b0; in_sop = 1'b0; Data_in_r = '0; Data_in_i = '0;
    #1 RST = 1'b0;
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sop", out_sop, 0);
    check("rst_data_r", Data_out_r, 0);
    check("rst_data_i", Data_out_i, 0);
    check("rst_frame_err", frame_err, 0);
    repeat (3) @(posedge CLK);
    #1 RST = 1'b1;

    // Samples without a leading in_sop are ignored.
    for (int k = 0; k < 20; k++) send(1'b1, 1'b0, W'($urandom), W'($urandom));
    idle(10);

    send_frame(0, 1'b1, N);
    wait_drain();

    for (int f = 0; f < 3; f++) send_frame(0, 1'b0, N);
    wait_drain();

    for (int f = 0; f < 2; f++) send_frame(5, 1'b0, N);
    wait_drain();

    send_frame(0, 1'b0, 100);
    send_frame(0, 1'b0, N);
    wait_drain();

    // Reset while bin 50 of a frame is on the output.
    send_frame(0, 1'b0, N);
    found = 0;
    for (int i = 0; i < N && !found; i++) begin
      @(negedge CLK);
      if (out_valid && out_sop) found = 1;
    end
    check("drain_started", found, 1);
    repeat (50) @(posedge CLK);
    #2 RST = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", {out_sop, Data_out_r, Data_out_i}, 0);
    sb.delete();
    frame_buf.delete();
    in_frame = 0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b1;
    idle(N + 20);
    send_frame(0, 1'b0, N);
    wait_drain();

    check("frame_err_pulses", err_seen, err_exp);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
